// File: rtl/div_issue_ctrl.sv
// Issue control, tag tracking and in-order result FIFO for an LAT-stage pipelined divider.
// Optional flush support is compiled in with `define DIVSCHED_FLUSH_EN.
module div_issue_ctrl #(
    parameter int LAT        = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_tag,
    input  logic        flush,
    output logic        div_is_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_tag,
    output logic        busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C   = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic kill;
`ifdef DIVSCHED_FLUSH_EN
    assign kill = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign kill         = 1'b0;
`endif

    logic [CW-1:0] inflight_cnt;
    logic [CW-1:0] fifo_cnt;
    logic          issue;
    logic          wr;
    logic          rd;
    logic [31:0]   wdata;

    // Credits cover both in-flight and buffered results, so a divider result always has a slot.
    assign req_ready = !rst && !kill &&
                       (({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < DEPTH_C);
    assign issue     = req_valid && req_ready;

    assign div_is_signed = issue & ~req_op[0];
    assign div_dividend  = issue ? req_rs1 : '0;
    assign div_divisor   = issue ? req_rs2 : '0;

    logic        trk_v   [LAT];
    logic        trk_rem [LAT];
    logic        trk_dz  [LAT];
    logic [4:0]  trk_tag [LAT];
    logic [31:0] trk_rs1 [LAT];

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                trk_v[i] <= 1'b0;
            end
        end else begin
            trk_v[0] <= issue;
            for (int unsigned i = 1; i < LAT; i++) begin
                trk_v[i] <= trk_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        trk_rem[0] <= req_op[1];
        trk_dz[0]  <= (req_rs2 == '0);
        trk_tag[0] <= req_tag;
        trk_rs1[0] <= req_rs1;
        for (int unsigned i = 1; i < LAT; i++) begin
            trk_rem[i] <= trk_rem[i-1];
            trk_dz[i]  <= trk_dz[i-1];
            trk_tag[i] <= trk_tag[i-1];
            trk_rs1[i] <= trk_rs1[i-1];
        end
    end

    assign wr = trk_v[LAT-1];

    // Divide-by-zero override; signed overflow already comes out right from the divider.
    always_comb begin
        wdata = div_quotient;
        if (trk_rem[LAT-1]) begin
            wdata = trk_dz[LAT-1] ? trk_rs1[LAT-1] : div_remainder;
        end else if (trk_dz[LAT-1]) begin
            wdata = '1;
        end
    end

    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [4:0]    mem_tag  [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign res_valid = (fifo_cnt != '0);
    assign rd        = res_valid && res_ready;
    assign res_data  = mem_data[rptr];
    assign res_tag   = mem_tag[rptr];

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
            end
        end else begin
            if (wr) begin
                mem_data[wptr] <= wdata;
                mem_tag[wptr]  <= trk_tag[LAT-1];
                wptr           <= ptr_inc(wptr);
            end
            if (rd) begin
                rptr <= ptr_inc(rptr);
            end
            case ({wr, rd})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            inflight_cnt <= '0;
        end else begin
            case ({issue, wr})
                2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

    assign busy = (inflight_cnt != '0) || (fifo_cnt != '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr && !kill && (fifo_cnt == FULL_C)));

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: pipelined divider model, queue-based reference model
// checked every cycle, and directed vectors with literal expectations.
module tb_div_issue_ctrl;
    localparam int LAT   = 8;
    localparam int DEPTH = 4;
`ifdef DIVSCHED_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        flush = 1'b0;
    logic        res_ready = 1'b1;
    logic [1:0]  req_op = '0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [4:0]  req_tag = '0;
    logic        req_ready, div_is_signed, res_valid, busy;
    logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder, res_data;
    logic [4:0]  res_tag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .flush(flush), .div_is_signed(div_is_signed), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .busy(busy)
    );

    // RISC-V M-extension result for a request, including the divide-by-zero rules.
    function automatic logic [31:0] expect_res(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Divider: LAT register stages; divisor 0 yields junk the controller must override.
    function automatic logic [63:0] divm(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {32'h1234_5678, 32'h0BAD_F00D};
        return {expect_res({1'b0, ~s}, a, b), expect_res({1'b1, ~s}, a, b)};
    endfunction

    logic [63:0] dpipe [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) dpipe[i] <= '0;
        end else begin
            dpipe[0] <= divm(div_is_signed, div_dividend, div_divisor);
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        end
    end
    assign {div_quotient, div_remainder} = dpipe[LAT-1];

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          due;
    } ent_t;
    ent_t infl[$];
    ent_t fbuf[$];
    int   cyc = 0;

    function automatic logic m_ready();
        return !rst && !(FLUSH_EN && flush) && ((infl.size() + fbuf.size()) < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: issue at edge c lands in the buffer at edge c+LAT.
    initial begin
        ent_t e;
        logic rdy;
        forever begin
            @(posedge clk);
            if (rst || (FLUSH_EN && flush)) begin
                infl.delete();
                fbuf.delete();
            end else begin
                rdy = m_ready();
                if (res_ready && fbuf.size() > 0) void'(fbuf.pop_front());
                if (infl.size() > 0 && infl[0].due == cyc) fbuf.push_back(infl.pop_front());
                if (req_valid && rdy) begin
                    e.data = expect_res(req_op, req_rs1, req_rs2);
                    e.tag  = req_tag;
                    e.due  = cyc + LAT;
                    infl.push_back(e);
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_req_ready", {31'd0, req_ready}, {31'd0, m_ready()});
            chk("m_res_valid", {31'd0, res_valid}, {31'd0, fbuf.size() > 0});
            chk("m_busy", {31'd0, busy}, {31'd0, (infl.size() + fbuf.size()) != 0});
            if (fbuf.size() > 0) begin
                chk("m_res_data", res_data, fbuf[0].data);
                chk("m_res_tag", {27'd0, res_tag}, {27'd0, fbuf[0].tag});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] t);
        req_valid = v;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = t;
    endtask

    task automatic wait_res(input string name, input logic [31:0] d, input logic [4:0] t);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
        end
        chk({name, "_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            chk({name, "_data"}, res_data, d);
            chk({name, "_tag"}, {27'd0, res_tag}, {27'd0, t});
        end
        tick();
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int n = 0; n < 100 && !idle; n++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        chk("drain_idle", {31'd0, idle}, 32'd1);
        tick();
    endtask

    task automatic scan_quiet(input string name);
        int seen;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk(name, 32'(seen), 32'd0);
        tick();
    endtask

    initial begin
        int   lat, k;
        logic got, rdy;

        tick();
        tick();
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_tag", {27'd0, res_tag}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        tick();

        // DIVU 100/7: first visible LAT edges after the issue edge
        set_req(1'b1, 2'b01, 32'd100, 32'd7, 5'd3);
        tick();
        set_req(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        got = 1'b0;
        lat = -1;
        for (int n = 0; n <= 30 && !got; n++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                lat = n;
            end
        end
        chk("t1_latency", 32'(lat), 32'(LAT));
        chk("t1_data", res_data, 32'd14);
        chk("t1_tag", {27'd0, res_tag}, 32'd3);
        tick();

        set_req(1'b1, 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1);
        tick();
        set_req(1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2);
        tick();
        set_req(1'b1, 2'b11, 32'd7, 32'd0, 5'd4);
        tick();
        set_req(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        wait_res("t2_div", 32'hFFFF_FFFD, 5'd1);
        wait_res("t2_rem", 32'hFFFF_FFFF, 5'd2);
        wait_res("t2_remu_dz", 32'd7, 5'd4);

        set_req(1'b1, 2'b00, 32'd5, 32'd0, 5'd5);
        tick();
        set_req(1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        tick();
        set_req(1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        tick();
        set_req(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        wait_res("t3_div_dz", 32'hFFFF_FFFF, 5'd5);
        wait_res("t3_div_ovf", 32'h8000_0000, 5'd6);
        wait_res("t3_rem_ovf", 32'd0, 5'd7);
        wait_idle();

        // Credit limit: DIVU (30+3k)/3 = 10+k, tag 10+k
        res_ready = 1'b0;
        k = 0;
        set_req(1'b1, 2'b01, 32'(30 + 3 * k), 32'd3, 5'(10 + k));
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rdy = req_ready;
            tick();
            if (rdy) begin
                k++;
                set_req(1'b1, 2'b01, 32'(30 + 3 * k), 32'd3, 5'(10 + k));
            end
        end
        chk("t4_accepted", 32'(k), 32'(DEPTH));
        chk("t4_stalled", {31'd0, req_ready}, 32'd0);
        res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            rdy = req_ready;
            chk("t4_pop_valid", {31'd0, res_valid}, 32'd1);
            chk("t4_pop_data", res_data, 32'(10 + j));
            chk("t4_pop_tag", {27'd0, res_tag}, 32'(10 + j));
            tick();
            if (rdy) begin
                k++;
                set_req(1'b1, 2'b01, 32'(30 + 3 * k), 32'd3, 5'(10 + k));
            end
        end
        set_req(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        wait_idle();

`ifdef DIVSCHED_FLUSH_EN
        set_req(1'b1, 2'b01, 32'd90, 32'd9, 5'd20);
        tick();
        set_req(1'b1, 2'b00, 32'd91, 32'd0, 5'd21);
        tick();
        set_req(1'b1, 2'b10, 32'd92, 32'd5, 5'd22);
        tick();
        set_req(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        tick();
        flush = 1'b1;
        set_req(1'b1, 2'b01, 32'd5, 32'd1, 5'd23);
        @(negedge clk);
        chk("t5_flush_ready", {31'd0, req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        set_req(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_valid", {31'd0, res_valid}, 32'd0);
        tick();
        scan_quiet("t5_no_stale");
        set_req(1'b1, 2'b01, 32'd9, 32'd3, 5'd9);
        tick();
        set_req(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        wait_res("t5_after", 32'd3, 5'd9);
`endif

        // Reset with the pipe full of work
        for (int c = 0; c < 5; c++) begin
            set_req(1'b1, 2'b01, 32'(200 + c), 32'd7, 5'(c + 24));
            tick();
        end
        set_req(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_valid", {31'd0, res_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        tick();
        scan_quiet("t6_no_stale");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
